// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, scheduler states and refresh-debt limits
package sdram_pkg;

  // {CS,RAS,CAS,WE}, active-low; also used by the SDRAM datapath
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT_WAIT = 3'd0;
  localparam state_t ST_INIT_PRE  = 3'd1;
  localparam state_t ST_INIT_REF1 = 3'd2;
  localparam state_t ST_INIT_REF2 = 3'd3;
  localparam state_t ST_INIT_MRS  = 3'd4;
  localparam state_t ST_IDLE      = 3'd5;
  localparam state_t ST_REF       = 3'd6;
  localparam state_t ST_CPU       = 3'd7;

  // JEDEC allows up to 8 postponed refreshes; force one before the limit
  localparam int DEBT_MAX   = 8;
  localparam int DEBT_FORCE = 6;

endpackage

// File: rtl/sdram_sched_if.sv
// rtl/sdram_sched_if.sv - handshake and command bus between scheduler, CPU side and datapath
interface sdram_sched_if;
  logic        REQ;
  logic        DONE;
  logic        GNT;
  logic        OWN;
  logic [3:0]  CMD;
  logic [12:0] ADDR;
  logic        READY;
  logic [3:0]  REF_DEBT;
  logic        REF_OVF;

  modport master (
    output REQ, DONE,
    input  GNT, OWN, CMD, ADDR, READY, REF_DEBT, REF_OVF
  );

  modport slave (
    input  REQ, DONE,
    output GNT, OWN, CMD, ADDR, READY, REF_DEBT, REF_OVF
  );
endinterface

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - refresh interval counter, outstanding-refresh debt and sticky overflow
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tick_en,
  input  logic       ref_issued,
  output logic       tick,
  output logic [3:0] ref_debt,
  output logic       ref_ovf
);

  logic [15:0] ival;

  // the wrap cycle of the interval counter is the refresh tick
  assign tick = tick_en && (ival == 16'(REF_INTERVAL - 1));

  // interval counter runs only once init is complete
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ival <= 16'd0;
    end else if (tick_en) begin
      ival <= tick ? 16'd0 : ival + 16'd1;
    end
  end

  // debt: +1 per tick, -1 per issued refresh, saturating with sticky overflow
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ref_debt <= 4'd0;
      ref_ovf  <= 1'b0;
    end else if (tick && !ref_issued) begin
      if (ref_debt == 4'(DEBT_MAX)) begin
        ref_ovf <= 1'b1;
      end else begin
        ref_debt <= ref_debt + 4'd1;
      end
    end else if (ref_issued && !tick && (ref_debt != 4'd0)) begin
      ref_debt <= ref_debt - 4'd1;
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// rtl/sdram_sched.sv - SDRAM command scheduler: init, refresh, CPU grant; SDRAM_SCHED_DEBT_EN selects CPU-first arbitration
module sdram_sched
  import sdram_pkg::*;
#(
  parameter int          INIT_WAIT    = 20000,
  parameter int          REF_INTERVAL = 780,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          T_MRD        = 2,
  parameter logic [12:0] MODE_WORD    = 13'h022
) (
  input  logic         CLK,
  input  logic         RESET,
  sdram_sched_if.slave bus
);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  cmd_q, cmd_n;
  logic [12:0] addr_q, addr_n;
  logic        gnt_q, gnt_n;
  logic        own_q, own_n;
  logic        ready_q;
  logic        tick;
  logic        ref_issued;
  logic        ref_need;
  logic [3:0]  ref_debt;
  logic        ref_ovf;

  // count 0 of the REF state is the AUTO_REFRESH command cycle
  assign ref_issued = (state == ST_REF) && (cnt == 16'd0);
  // a tick in the arbitration cycle already counts as pending debt
  assign ref_need   = (ref_debt != 4'd0) || tick;

  sdram_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .tick_en    (ready_q),
    .ref_issued (ref_issued),
    .tick       (tick),
    .ref_debt   (ref_debt),
    .ref_ovf    (ref_ovf)
  );

  // next state: each command state issues at count 0, then waits out its timing
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    case (state)
      ST_INIT_WAIT: if (cnt == 16'(INIT_WAIT - 1)) begin state_n = ST_INIT_PRE;  cnt_n = 16'd0; end
      ST_INIT_PRE:  if (cnt == 16'(T_RP))          begin state_n = ST_INIT_REF1; cnt_n = 16'd0; end
      ST_INIT_REF1: if (cnt == 16'(T_RFC))         begin state_n = ST_INIT_REF2; cnt_n = 16'd0; end
      ST_INIT_REF2: if (cnt == 16'(T_RFC))         begin state_n = ST_INIT_MRS;  cnt_n = 16'd0; end
      ST_INIT_MRS:  if (cnt == 16'(T_MRD))         begin state_n = ST_IDLE;      cnt_n = 16'd0; end
      ST_REF:       if (cnt == 16'(T_RFC))         begin state_n = ST_IDLE;      cnt_n = 16'd0; end
      ST_IDLE: begin
        cnt_n = 16'd0;
`ifdef SDRAM_SCHED_DEBT_EN
        if (bus.REQ && (ref_debt < 4'(DEBT_FORCE))) state_n = ST_CPU;
        else if (ref_need)                          state_n = ST_REF;
`else
        if (ref_need)     state_n = ST_REF;
        else if (bus.REQ) state_n = ST_CPU;
`endif
      end
      ST_CPU: begin
        cnt_n = 16'd0;
        if (bus.DONE || !bus.REQ) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_INIT_WAIT;
        cnt_n   = 16'd0;
      end
    endcase
  end

  // bus outputs for the state being entered, so they register alongside it
  always_comb begin
    cmd_n  = CMD_NOP;
    addr_n = 13'd0;
    gnt_n  = 1'b0;
    own_n  = 1'b1;
    case (state_n)
      ST_INIT_PRE: if (cnt_n == 16'd0) begin cmd_n = CMD_PRE; addr_n[10] = 1'b1; end
      ST_INIT_REF1, ST_INIT_REF2, ST_REF: if (cnt_n == 16'd0) cmd_n = CMD_REF;
      ST_INIT_MRS: if (cnt_n == 16'd0) begin cmd_n = CMD_MRS; addr_n = MODE_WORD; end
      ST_CPU: begin gnt_n = 1'b1; own_n = 1'b0; end
      default: ;
    endcase
  end

  // state and registered bus outputs; reset deselects the bus and drops any grant
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_INIT_WAIT;
      cnt     <= 16'd0;
      cmd_q   <= CMD_DESEL;
      addr_q  <= 13'd0;
      gnt_q   <= 1'b0;
      own_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cmd_q   <= cmd_n;
      addr_q  <= addr_n;
      gnt_q   <= gnt_n;
      own_q   <= own_n;
      ready_q <= ready_q | (state_n == ST_IDLE);
    end
  end

  assign bus.CMD      = cmd_q;
  assign bus.ADDR     = addr_q;
  assign bus.GNT      = gnt_q;
  assign bus.OWN      = own_q;
  assign bus.READY    = ready_q;
  assign bus.REF_DEBT = ref_debt;
  assign bus.REF_OVF  = ref_ovf;

endmodule

// File: tb/tb_sdram_sched.sv
// tb/tb_sdram_sched.sv - directed self-checking bench for sdram_sched
module tb_sdram_sched;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;
  int   cyc;
  int   n_ref;
  int   first_ref_debt;
  int   max_debt;
  logic got;

  sdram_sched_if sif ();

  sdram_sched #(
    .INIT_WAIT    (10),
    .REF_INTERVAL (50),
    .T_RP         (2),
    .T_RFC        (3),
    .T_MRD        (2),
    .MODE_WORD    (13'h022)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (sif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  function automatic logic [3:0] init_cmd(input int k);
    case (k)
      10:      return 4'b0010;
      13, 17:  return 4'b0001;
      21:      return 4'b0000;
      default: return 4'b0111;
    endcase
  endfunction

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    RESET = 1'b1;
    sif.REQ = 1'b0;
    sif.DONE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    check("rst_cmd",   sif.CMD,      4'hF);
    check("rst_gnt",   sif.GNT,      1'b0);
    check("rst_own",   sif.OWN,      1'b1);
    check("rst_addr",  sif.ADDR,     13'h0);
    check("rst_ready", sif.READY,    1'b0);
    check("rst_debt",  sif.REF_DEBT, 4'd0);
    check("rst_ovf",   sif.REF_OVF,  1'b0);

    // init: PRE@10, REF@13/17, MRS@21, READY@24
    RESET = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("init_cmd", sif.CMD, init_cmd(k));
      if (k == 10) check("init_pre_addr", sif.ADDR, 13'h400);
      if (k == 21) check("init_mrs_addr", sif.ADDR, 13'h022);
      if (k == 23) check("init_not_ready", sif.READY, 1'b0);
    end
    check("init_ready", sif.READY, 1'b1);

    // idle refresh: ticks at 73/123/173, refresh one cycle later
    for (int k = 25; k <= 180; k++) begin
      step();
      check("idle_ref", (sif.CMD == 4'b0001), (k == 74 || k == 124 || k == 174));
      check("idle_debt", sif.REF_DEBT, (k == 74 || k == 124 || k == 174) ? 4'd1 : 4'd0);
    end

    // grant handshake
    check("pre_grant_gnt", sif.GNT, 1'b0);
    sif.REQ = 1'b1;
    step();
    check("grant_gnt", sif.GNT, 1'b1);
    check("grant_own", sif.OWN, 1'b0);
    repeat (10) begin
      step();
      check("grant_hold", sif.GNT, 1'b1);
    end
    sif.DONE = 1'b1;
    sif.REQ = 1'b0;
    step();
    check("done_gnt", sif.GNT, 1'b0);
    check("done_own", sif.OWN, 1'b1);
    step();
    check("stray_done_gnt", sif.GNT, 1'b0);
    check("stray_done_cmd", sif.CMD, 4'b0111);
    sif.DONE = 1'b0;

    // tie: REQ rises in tick cycle 223, refresh goes first
    goto(223);
    sif.REQ = 1'b1;
    step();
    check("tie_ref_cmd", sif.CMD, 4'b0001);
    check("tie_ref_gnt", sif.GNT, 1'b0);
    check("tie_ref_debt", sif.REF_DEBT, 4'd1);
    goto(228);
    check("tie_idle_gnt", sif.GNT, 1'b0);
    step();
    check("tie_gnt", sif.GNT, 1'b1);
    check("tie_own", sif.OWN, 1'b0);

    // CPU holds the bus through 9 ticks: debt saturates, overflow latches
    goto(624);
    check("sat_debt8", sif.REF_DEBT, 4'd8);
    check("sat_no_ovf", sif.REF_OVF, 1'b0);
    check("sat_gnt", sif.GNT, 1'b1);
    goto(673);
    check("sat_ovf_before", sif.REF_OVF, 1'b0);
    step();
    check("sat_ovf", sif.REF_OVF, 1'b1);
    check("sat_debt_held", sif.REF_DEBT, 4'd8);

    // release: eight back-to-back refreshes pay the debt back
    sif.REQ = 1'b0;
    n_ref = 0;
    while (cyc < 716) begin
      step();
      if (sif.CMD == 4'b0001) n_ref++;
    end
    check("drain_count", n_ref, 8);
    check("drain_debt", sif.REF_DEBT, 4'd0);
    check("drain_ovf_sticky", sif.REF_OVF, 1'b1);

    // REQ held with DONE every 20 cycles
    sif.REQ = 1'b1;
    first_ref_debt = -1;
    max_debt = 0;
    while (cyc < 1000) begin
      step();
      sif.DONE = (cyc % 20 == 0);
      if (int'(sif.REF_DEBT) > max_debt) max_debt = int'(sif.REF_DEBT);
      if (sif.CMD == 4'b0001 && first_ref_debt < 0) first_ref_debt = int'(sif.REF_DEBT);
    end
    sif.DONE = 1'b0;
`ifdef SDRAM_SCHED_DEBT_EN
    check("debt_forced_at", first_ref_debt, 6);
    check("debt_max", max_debt, 6);
`else
    check("busy_first_ref_debt", first_ref_debt, 1);
    check("busy_max_debt", max_debt, 1);
`endif

    // reset while granted
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (sif.GNT === 1'b1) got = 1'b1;
    end
    check("mid_grant_seen", got, 1'b1);
    #3;
    RESET = 1'b1;
    #1;
    check("async_gnt",   sif.GNT,      1'b0);
    check("async_ready", sif.READY,    1'b0);
    check("async_cmd",   sif.CMD,      4'hF);
    check("async_own",   sif.OWN,      1'b1);
    check("async_debt",  sif.REF_DEBT, 4'd0);
    check("async_ovf",   sif.REF_OVF,  1'b0);
    sif.REQ = 1'b0;
    #2;
    RESET = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("reinit_cmd", sif.CMD, init_cmd(k));
    end
    check("reinit_ready", sif.READY, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_sched.md
Name: sdram_sched

Overview:
- Command scheduler in front of the SDRAM datapath, clocked from the 100 MHz RAM clock.
- Runs the power-up init sequence: wait, precharge-all, two auto-refreshes, mode-register set.
- Generates periodic auto-refresh and arbitrates the command bus between refresh and CPU (68030) accesses.
- The SDRAM datapath issues ACTIVE/READ/WRITE only while GNT=1. All CPU accesses end with auto-precharge.

Parameters:
- INIT_WAIT, 20000: power-up wait in CLK cycles (200 us).
- REF_INTERVAL, 780: cycles between refresh ticks (7.8 us).
- T_RP, 2: precharge-to-command cycles.
- T_RFC, 7: refresh-to-command cycles.
- T_MRD, 2: mode-set-to-command cycles.
- MODE_WORD, 13'h022: value placed on ADDR during MRS (CAS 2, burst 4).

Ports:
- CLK  in  1  RAM clock (100 MHz).
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  1  CPU access request, level; held until DONE or cycle abort.
- DONE  in  1  one-cycle pulse from datapath: access complete, bank precharged.
- GNT  out  1  datapath owns the SDRAM command bus.
- OWN  out  1  scheduler drives CMD/ADDR this cycle.
- CMD  out  4  {CS,RAS,CAS,WE}, active-low.
- ADDR  out  13  SDRAM address during scheduler commands.
- READY  out  1  init complete.
- REF_DEBT  out  4  outstanding refreshes.
- REF_OVF  out  1  sticky: debt limit exceeded.

Behaviour:
- Reset values: GNT=0, OWN=1, CMD=4'b1111 (deselect), ADDR=0, READY=0, REF_DEBT=0, REF_OVF=0; state INIT_WAIT; counters cleared.
- RESET mid-operation: everything returns to reset values immediately. An active grant is dropped; the datapath must abandon its cycle.
- Command encodings: NOP 0111, PRECHARGE 0010 (ADDR[10]=1 for all banks), AUTO_REFRESH 0001, MRS 0000. Between commands OWN=1 and CMD=NOP.
- INIT_WAIT: count INIT_WAIT cycles issuing NOP, then go to INIT_PRE.
- INIT_PRE: one PRECHARGE-all cycle, then T_RP NOP cycles.
- INIT_REF1, INIT_REF2: each is one AUTO_REFRESH cycle followed by T_RFC NOP cycles.
- INIT_MRS: one MRS cycle with ADDR=MODE_WORD, then T_MRD NOP cycles, then IDLE. READY=1 from the first IDLE cycle and stays high until RESET.
- Interval counter:
  - Runs only while READY=1, from 0 to REF_INTERVAL-1, then wraps.
  - The wrap cycle is a tick: REF_DEBT +1.
  - Each AUTO_REFRESH issued from IDLE: REF_DEBT -1.
  - Tick and issue in the same cycle: debt unchanged.
- IDLE arbitration (without DEBT feature):
  - REF_DEBT>0 goes to REF, even if REQ=1 (refresh wins ties).
  - Otherwise REQ=1 goes to CPU.
- REF: one AUTO_REFRESH cycle, T_RFC NOP cycles, back to IDLE.
- CPU state:
  - GNT=1 and OWN=0 from the cycle after IDLE sees REQ. Grant latency is 1 cycle from REQ when idle.
  - DONE=1 clears GNT next cycle, returns to IDLE, OWN=1.
  - REQ dropping without DONE: CPU cycle aborted; GNT clears next cycle. Datapath guarantees the bank is precharged.
  - Ticks still accumulate debt while in CPU.
  - DONE outside the CPU state is ignored.
- Debt limit: REF_DEBT saturates at 8. A tick at 8 sets REF_OVF, which is cleared only by RESET.
- REQ and DONE are synchronous to CLK; the upstream logic synchronises AS30.

Optional Feature:
- Macro SDRAM_SCHED_DEBT_EN.
- With it defined:
  - IDLE prefers the CPU: REQ=1 and REF_DEBT<6 goes to CPU.
  - Refresh runs when REQ=0 and REF_DEBT>0, or when REF_DEBT>=6 (forced, ahead of REQ).
  - Refreshes may be postponed, up to the 8-refresh JEDEC allowance.
- Without it: refresh-first arbitration as described under Behaviour. REF_DEBT cannot exceed 1 in normal operation.

Decomposition:
- Shared package sdram_pkg holds:
  - command encodings (CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS, CMD_DESEL);
  - state enumeration;
  - debt limit (8) and forced-refresh threshold (6).
- The same encodings are reused by the sdram datapath.
- One natural sub-module, sdram_refresh_timer: interval counter plus debt counter and REF_OVF. Inputs tick-enable and refresh-issued; outputs REF_DEBT and REF_OVF.

Test Plan:
- Init sequence (INIT_WAIT=10, T_RP=2, T_RFC=3, T_MRD=2): release RESET, then expect in order:
  - PRE at cycle 10;
  - REF at 13 and at 17;
  - MRS with ADDR=13'h022 at 21;
  - READY=1 at cycle 24.
- Idle refresh (REF_INTERVAL=50, REQ=0): exactly one AUTO_REFRESH within 2 cycles of each tick; REF_DEBT returns to 0.
- Grant handshake: REQ=1 in IDLE, then GNT=1 and OWN=0 the next cycle. Hold 10 cycles, pulse DONE, then GNT=0 the next cycle.
- Tie: tick and REQ rise in the same IDLE cycle (feature off): AUTO_REFRESH issued first, then GNT=1 on cycle T_RFC+2.
- Debt with SDRAM_SCHED_DEBT_EN, REQ held high across 6 ticks with DONE every 20 cycles: CPU is granted until REF_DEBT=6, then refresh is forced. Hold REQ with no DONE for 9 ticks: REF_OVF=1.
- Reset mid-grant: assert RESET while GNT=1. GNT=0, READY=0, CMD=1111 asynchronously; the init sequence restarts on release.
